gbt_link_sequencer: RTL and testbench
=====================================

GBT_LINK_SEQUENCER -- requirements
Module: gbt_link_sequencer

Interface
REQ-001 Parameter RESET_HOLD_CYCLES, default 16: cycles general_reset_o is held per reset.
REQ-002 Parameter LOCK_TIMEOUT_CYCLES, default 1024: cycles to wait for link_ready before a bitslip retry.
REQ-003 Parameter BITSLIP_PULSE_CYCLES, default 4: bitslip_reset_o pulse width.
REQ-004 Parameter MAX_RETRIES, default 8: bitslip retries before FAIL; range 1..15.
REQ-005 Parameter DROP_FILTER_CYCLES, default 4: consecutive synchronised link_ready-low cycles in LINK_UP that count as link loss.
REQ-006 ClkRs_ix.clk  input  1  40 MHz frame clock; the only clock.
REQ-007 ClkRs_ix.reset  input  1  asynchronous, active-high reset.
REQ-008 sfp_los_i  input  1  SFP loss of signal, asynchronous, high = no light.
REQ-009 user_reset_i  input  1  synchronous request for a full relink; level or pulse.
REQ-010 link_ready_i  input  1  GBT bank link-ready, asynchronous.
REQ-011 general_reset_o  output  1  GBT bank general reset.
REQ-012 bitslip_reset_o  output  1  GBT bank RX bitslip reset-on-even.
REQ-013 link_up_o  output  1  high only in LINK_UP.
REQ-014 link_fail_o  output  1  high only in FAIL.
REQ-015 retry_count_o  output  4  bitslip retries issued since the last GEN_RESET entry.
REQ-016 state_o  output  3  current state: IDLE=0, GEN_RESET=1, WAIT_LOCK=2, BITSLIP=3, LINK_UP=4, FAIL=5.

Function
REQ-017 sfp_los_i and link_ready_i SHALL pass through 2-FF synchronisers; all logic below uses the synchronised versions (los_s, rdy_s), giving 2 cycles of input latency.
REQ-018 All outputs SHALL be registered and decoded from the state register and counters with no combinational path from any input.
REQ-019 One cycle counter SHALL be cleared on every state entry, with width ceil(log2(max(RESET_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES)))+1 bits, saturating and never wrapping.
REQ-020 IDLE: general_reset_o=1; exit to GEN_RESET when los_s=0.
REQ-021 GEN_RESET: general_reset_o=1 for exactly RESET_HOLD_CYCLES cycles, then WAIT_LOCK; retry_count cleared on entry.
REQ-022 WAIT_LOCK: general_reset_o=0; rdy_s=1 -> LINK_UP next cycle; counter reaching LOCK_TIMEOUT_CYCLES-1 with rdy_s=0 -> BITSLIP if retry_count<MAX_RETRIES, otherwise FAIL.
REQ-023 BITSLIP: bitslip_reset_o=1 for exactly BITSLIP_PULSE_CYCLES cycles; retry_count increments by 1 on entry; then WAIT_LOCK with the counter cleared.
REQ-024 LINK_UP: link_up_o=1; rdy_s=0 for DROP_FILTER_CYCLES consecutive cycles -> GEN_RESET; shorter glitches reset the drop counter and are ignored.
REQ-025 FAIL: general_reset_o=0 and link_fail_o=1; held until user_reset_i or LOS.
REQ-026 Priority, evaluated every cycle: los_s=1 -> IDLE from any state; else user_reset_i=1 -> GEN_RESET from any state except IDLE; else the per-state rules above.
REQ-027 user_reset_i held high SHALL keep re-entering GEN_RESET, keeping general_reset_o high; the hold count starts on its falling edge.
REQ-028 rdy_s=1 on the same cycle as the WAIT_LOCK timeout SHALL take LINK_UP; lock wins over retry.
REQ-029 retry_count_o SHALL saturate at 15 and SHALL hold its value in LINK_UP and FAIL for diagnostics.

Reset
REQ-030 ClkRs_ix.reset=1 SHALL asynchronously force IDLE, clear counters and retry_count, set general_reset_o=1 and set all other outputs to 0; synchroniser flops reset to los=1 and rdy=0.
REQ-031 After reset release, the block SHALL leave IDLE no earlier than 2 cycles later (synchroniser latency), even if sfp_los_i=0.

Verification
REQ-032 Reset release, sfp_los_i=0, link_ready_i rises 100 cycles after WAIT_LOCK entry -> general_reset_o high for exactly 16 cycles, then link_up_o=1 about 3 cycles after the rise, retry_count_o=0.
REQ-033 link_ready_i held 0 -> 8 bitslip pulses of 4 cycles each, spaced 1024+4 cycles apart, then link_fail_o=1, state_o=5, retry_count_o=8.
REQ-034 In LINK_UP, a 3-cycle low glitch on link_ready_i -> stays in LINK_UP; a 4-cycle low -> GEN_RESET, 16-cycle general_reset_o, retry_count_o=0.
REQ-035 sfp_los_i asserted during BITSLIP -> IDLE within 3 cycles, bitslip_reset_o=0, general_reset_o=1; deassertion restarts from GEN_RESET.
REQ-036 In FAIL, 1-cycle user_reset_i -> GEN_RESET next cycle, retry_count_o=0, link_fail_o=0; link_ready_i asserted on the WAIT_LOCK timeout cycle -> LINK_UP, no bitslip pulse.
REQ-037 Assert ClkRs_ix.reset mid-GEN_RESET -> outputs take their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/gbt_link_sequencer_if.sv
// ============================================================================
//  Module   : gbt_link_sequencer_if
//  Purpose  : Signal bundle between a GBT link sequencer and its environment.
//             The slave modport is the sequencer side; the master modport is
//             the side that drives the link status inputs and observes the
//             sequencer outputs.
//  Signals  : sfp_los_i       SFP loss of signal (async, high = no light)
//             user_reset_i    synchronous full-relink request
//             link_ready_i    GBT bank link-ready (async)
//             general_reset_o GBT bank general reset
//             bitslip_reset_o GBT bank RX bitslip reset-on-even
//             link_up_o       high only in LINK_UP
//             link_fail_o     high only in FAIL
//             retry_count_o   bitslip retries since the last GEN_RESET entry
//             state_o         current sequencer state
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gbt_link_sequencer_if;
   logic       sfp_los_i;
   logic       user_reset_i;
   logic       link_ready_i;
   logic       general_reset_o;
   logic       bitslip_reset_o;
   logic       link_up_o;
   logic       link_fail_o;
   logic [3:0] retry_count_o;
   logic [2:0] state_o;

   modport master (
      output sfp_los_i, user_reset_i, link_ready_i,
      input  general_reset_o, bitslip_reset_o, link_up_o, link_fail_o,
             retry_count_o, state_o
   );

   modport slave (
      input  sfp_los_i, user_reset_i, link_ready_i,
      output general_reset_o, bitslip_reset_o, link_up_o, link_fail_o,
             retry_count_o, state_o
   );
endinterface

`default_nettype wire

// File: rtl/gbt_link_sequencer.sv
// ============================================================================
//  Module   : gbt_link_sequencer
//  Purpose  : Brings up a GBT link: holds the bank in general reset, waits
//             for link-ready, issues bitslip-reset pulses on lock timeout,
//             declares FAIL after too many retries, and watches for link loss.
//  Ports    : clk      40 MHz frame clock
//             rst      asynchronous active-high reset
//             io_link  sequencer side (slave) of gbt_link_sequencer_if
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gbt_link_sequencer #(
   parameter int unsigned RESET_HOLD_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT_CYCLES  = 1024,
   parameter int unsigned BITSLIP_PULSE_CYCLES = 4,
   parameter int unsigned MAX_RETRIES          = 8,
   parameter int unsigned DROP_FILTER_CYCLES   = 4
) (
   input  wire logic            clk,
   input  wire logic            rst,
   gbt_link_sequencer_if.slave  io_link
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_GEN_RESET = 3'd1,
      ST_WAIT_LOCK = 3'd2,
      ST_BITSLIP   = 3'd3,
      ST_LINK_UP   = 3'd4,
      ST_FAIL      = 3'd5
   } state_t;

   localparam int unsigned c_CNT_MAX = (RESET_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                       RESET_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int unsigned c_CNT_W   = $clog2(c_CNT_MAX) + 1;

   localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(RESET_HOLD_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_TMO_LAST   = c_CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_PULSE_LAST = c_CNT_W'(BITSLIP_PULSE_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_DROP_LAST  = c_CNT_W'(DROP_FILTER_CYCLES - 1);
   localparam logic [3:0]         c_MAX_RETRY  = 4'(MAX_RETRIES);

   // Synchronisers reset to the "no light, not ready" condition.
   logic r_los_meta, r_los_s;
   logic r_rdy_meta, r_rdy_s;

   state_t             r_state, w_state_nxt;
   logic               w_enter;
   logic [c_CNT_W-1:0] r_cnt;
   logic [3:0]         r_retry;
   logic               r_gen_rst, r_bitslip, r_link_up, r_link_fail;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_los_meta <= 1'b1;
         r_los_s    <= 1'b1;
         r_rdy_meta <= 1'b0;
         r_rdy_s    <= 1'b0;
      end else begin
         r_los_meta <= io_link.sfp_los_i;
         r_los_s    <= r_los_meta;
         r_rdy_meta <= io_link.link_ready_i;
         r_rdy_s    <= r_rdy_meta;
      end
   end

   // Next state. w_enter marks every state entry, including re-entry of
   // GEN_RESET while user_reset_i stays high, so the cycle counter restarts.
   always_comb begin
      w_state_nxt = r_state;
      w_enter     = 1'b0;
      if (r_los_s) begin
         w_state_nxt = ST_IDLE;
         w_enter     = (r_state != ST_IDLE);
      end else if (io_link.user_reset_i && (r_state != ST_IDLE)) begin
         w_state_nxt = ST_GEN_RESET;
         w_enter     = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_GEN_RESET;
               w_enter     = 1'b1;
            end
            ST_GEN_RESET: begin
               if (r_cnt == c_HOLD_LAST) begin
                  w_state_nxt = ST_WAIT_LOCK;
                  w_enter     = 1'b1;
               end
            end
            ST_WAIT_LOCK: begin
               // Lock is tested first so it wins over a coincident timeout.
               if (r_rdy_s) begin
                  w_state_nxt = ST_LINK_UP;
                  w_enter     = 1'b1;
               end else if (r_cnt == c_TMO_LAST) begin
                  w_state_nxt = (r_retry < c_MAX_RETRY) ? ST_BITSLIP : ST_FAIL;
                  w_enter     = 1'b1;
               end
            end
            ST_BITSLIP: begin
               if (r_cnt == c_PULSE_LAST) begin
                  w_state_nxt = ST_WAIT_LOCK;
                  w_enter     = 1'b1;
               end
            end
            ST_LINK_UP: begin
               // In LINK_UP the counter holds the run length of rdy_s low.
               if (!r_rdy_s && (r_cnt == c_DROP_LAST)) begin
                  w_state_nxt = ST_GEN_RESET;
                  w_enter     = 1'b1;
               end
            end
            ST_FAIL: begin
               w_state_nxt = ST_FAIL;
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_enter     = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_retry     <= 4'd0;
         r_gen_rst   <= 1'b1;
         r_bitslip   <= 1'b0;
         r_link_up   <= 1'b0;
         r_link_fail <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         if (w_enter || ((r_state == ST_LINK_UP) && r_rdy_s)) begin
            r_cnt <= '0;
         end else if (r_cnt != {c_CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + 1'b1;
         end

         if (w_enter && (w_state_nxt == ST_GEN_RESET)) begin
            r_retry <= 4'd0;
         end else if (w_enter && (w_state_nxt == ST_BITSLIP) && (r_retry != 4'hF)) begin
            r_retry <= r_retry + 4'd1;
         end

         // Outputs are registered from the next state so they line up with
         // r_state and never see an input combinationally.
         r_gen_rst   <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_GEN_RESET);
         r_bitslip   <= (w_state_nxt == ST_BITSLIP);
         r_link_up   <= (w_state_nxt == ST_LINK_UP);
         r_link_fail <= (w_state_nxt == ST_FAIL);
      end
   end

   assign io_link.general_reset_o = r_gen_rst;
   assign io_link.bitslip_reset_o = r_bitslip;
   assign io_link.link_up_o       = r_link_up;
   assign io_link.link_fail_o     = r_link_fail;
   assign io_link.retry_count_o   = r_retry;
   assign io_link.state_o         = r_state;

endmodule

`default_nettype wire

// File: tb/tb_gbt_link_sequencer.sv
`default_nettype none

module tb_gbt_link_sequencer;

   localparam int T_HOLD  = 16;
   localparam int T_LOCK  = 1024;
   localparam int T_PULSE = 4;
   localparam int N_RETRY = 8;
   localparam int T_DROP  = 4;

   localparam int S_IDLE = 0, S_GEN = 1, S_WAIT = 2, S_BS = 3, S_UP = 4, S_FAIL = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gbt_link_sequencer_if u_if ();

   gbt_link_sequencer #(
      .RESET_HOLD_CYCLES    (T_HOLD),
      .LOCK_TIMEOUT_CYCLES  (T_LOCK),
      .BITSLIP_PULSE_CYCLES (T_PULSE),
      .MAX_RETRIES          (N_RETRY),
      .DROP_FILTER_CYCLES   (T_DROP)
   ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .io_link (u_if)
   );

   // Expected state segment: state, length in cycles (0 = any), retry (-1 = any).
   typedef struct {
      int st;
      int len;
      int rty;
   } seg_t;

   seg_t q_exp[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_retry = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic summary_and_finish();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   endtask

   task automatic push(input int st, input int len, input int rty);
      seg_t s;
      s.st = st; s.len = len; s.rty = rty;
      q_exp.push_back(s);
   endtask

   // Returns at the first falling edge on which state_o equals s.
   task automatic wait_state(input int s);
      int n = 0;
      while (u_if.state_o !== 3'(s)) begin
         @(negedge clk);
         n++;
         if (n > 20000) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_state timeout: state_o=%0d expected %0d", u_if.state_o, s);
            summary_and_finish();
         end
      end
   endtask

   // ---------------- monitor: segments of constant state_o ----------------
   initial begin : p_monitor
      int   cur = -1;
      int   len = 0;
      int   rty = 0;
      seg_t e;
      forever begin
         @(negedge clk);
         // Output decode must follow the state at every sample.
         chk("output_decode",
             {u_if.general_reset_o, u_if.bitslip_reset_o, u_if.link_up_o, u_if.link_fail_o},
             {(u_if.state_o == 3'd0) || (u_if.state_o == 3'd1), u_if.state_o == 3'd3,
              u_if.state_o == 3'd4, u_if.state_o == 3'd5});
         if (int'(u_if.state_o) != cur) begin
            if (cur >= 0) begin
               if (q_exp.size() == 0) begin
                  chk("unexpected_segment_state", cur, 99);
               end else begin
                  e = q_exp.pop_front();
                  chk("segment_state", cur, e.st);
                  if (e.len > 0) chk("segment_length", len, e.len);
                  if (e.rty >= 0) chk("segment_retry", rty, e.rty);
               end
            end
            cur = int'(u_if.state_o);
            len = 1;
            rty = int'(u_if.retry_count_o);
         end else begin
            len++;
         end
      end
   end

   initial begin : p_watchdog
      #600000;
      n_tests++;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      summary_and_finish();
   end

   // ---------------- stimulus scenarios ----------------
   task automatic release_reset();
      int n = 0;
      @(negedge clk);
      rst = 1'b0;
      exp_retry = 0;
      push(S_GEN, T_HOLD, 0);
      @(negedge clk);
      while (u_if.state_o === 3'd0 && n < 10) begin
         n++;
         @(negedge clk);
      end
      chk("idle_exit_latency_ok", (n >= 2 && n <= 3), 1);
      wait_state(S_WAIT);
   endtask

   // At WAIT_LOCK entry: raise link_ready_i after d cycles.
   task automatic do_lock(input int d);
      push(S_WAIT, (d + 3 > T_LOCK) ? T_LOCK : d + 3, exp_retry);
      repeat (d) @(negedge clk);
      u_if.link_ready_i = 1'b1;
      wait_state(S_UP);
   endtask

   // At LINK_UP entry: short glitches, then a drop that must cause relink.
   task automatic linkup_drop(input int n_glitch);
      int el = 0;
      int g;
      for (int i = 0; i < n_glitch; i++) begin
         g = $urandom_range(20, 1);
         repeat (g) @(negedge clk);
         el += g;
         g = $urandom_range(T_DROP - 1, 1);
         u_if.link_ready_i = 1'b0;
         repeat (g) @(negedge clk);
         el += g;
         u_if.link_ready_i = 1'b1;
      end
      g = $urandom_range(20, 1);
      repeat (g) @(negedge clk);
      el += g;
      u_if.link_ready_i = 1'b0;
      push(S_UP, el + T_DROP + 2, exp_retry);
      exp_retry = 0;
      push(S_GEN, T_HOLD, 0);
      wait_state(S_WAIT);
   endtask

   // At WAIT_LOCK entry with link_ready_i low: retry until FAIL.
   task automatic exhaust();
      forever begin
         push(S_WAIT, T_LOCK, exp_retry);
         if (exp_retry < N_RETRY) begin
            exp_retry++;
            push(S_BS, T_PULSE, exp_retry);
            wait_state(S_BS);
            wait_state(S_WAIT);
         end else begin
            wait_state(S_FAIL);
            break;
         end
      end
   endtask

   task automatic fail_user_reset();
      int w = $urandom_range(10, 0);
      repeat (w) @(negedge clk);
      u_if.user_reset_i = 1'b1;
      push(S_FAIL, w + 1, exp_retry);
      exp_retry = 0;
      push(S_GEN, T_HOLD, 0);
      @(negedge clk);
      u_if.user_reset_i = 1'b0;
      wait_state(S_WAIT);
   endtask

   // At LINK_UP entry with link ready: hold user_reset_i for h cycles.
   task automatic user_reset_held(input int h);
      int k = $urandom_range(10, 1);
      repeat (k) @(negedge clk);
      u_if.user_reset_i = 1'b1;
      push(S_UP, k + 1, exp_retry);
      exp_retry = 0;
      push(S_GEN, h + T_HOLD - 1, 0);
      push(S_WAIT, 1, 0);
      repeat (h) @(negedge clk);
      u_if.user_reset_i = 1'b0;
      wait_state(S_UP);
   endtask

   // At WAIT_LOCK entry with link_ready_i low: LOS during the first pulse.
   task automatic los_in_bitslip();
      int w = $urandom_range(10, 1);
      push(S_WAIT, T_LOCK, exp_retry);
      exp_retry++;
      push(S_BS, 3, exp_retry);
      wait_state(S_BS);
      u_if.sfp_los_i = 1'b1;
      push(S_IDLE, w + 3, -1);
      wait_state(S_IDLE);
      repeat (w) @(negedge clk);
      u_if.sfp_los_i = 1'b0;
      exp_retry = 0;
      push(S_GEN, T_HOLD, 0);
      wait_state(S_WAIT);
   endtask

   initial begin : p_stim
      u_if.sfp_los_i    = 1'b0;
      u_if.user_reset_i = 1'b0;
      u_if.link_ready_i = 1'b0;
      push(S_IDLE, 0, 0);
      repeat (3) @(negedge clk);
      chk("reset_state", u_if.state_o, S_IDLE);
      chk("reset_general_reset", u_if.general_reset_o, 1);
      chk("reset_bitslip", u_if.bitslip_reset_o, 0);
      chk("reset_link_up", u_if.link_up_o, 0);
      chk("reset_retry", u_if.retry_count_o, 0);

      release_reset();
      do_lock(100);

      linkup_drop(3);
      do_lock($urandom_range(T_LOCK - 4, 0));

      linkup_drop(2);
      exhaust();
      chk("fail_retry_count", u_if.retry_count_o, N_RETRY);
      fail_user_reset();
      do_lock(T_LOCK - 3);

      user_reset_held($urandom_range(6, 1));

      linkup_drop(1);
      los_in_bitslip();
      do_lock($urandom_range(50, 0));

      // Asynchronous reset in the middle of GEN_RESET.
      begin
         int k = $urandom_range(8, 1);
         repeat (k) @(negedge clk);
         u_if.user_reset_i = 1'b1;
         push(S_UP, k + 1, exp_retry);
         push(S_GEN, 0, 0);
         @(negedge clk);
         u_if.user_reset_i = 1'b0;
         u_if.link_ready_i = 1'b0;
         repeat ($urandom_range(10, 2)) @(negedge clk);
         #2;
         rst = 1'b1;
         push(S_IDLE, 0, 0);
         #1;
         chk("async_rst_state", u_if.state_o, S_IDLE);
         chk("async_rst_general_reset", u_if.general_reset_o, 1);
         chk("async_rst_others", {u_if.bitslip_reset_o, u_if.link_up_o, u_if.link_fail_o}, 0);
         chk("async_rst_retry", u_if.retry_count_o, 0);
      end
      repeat (3) @(negedge clk);
      release_reset();
      do_lock($urandom_range(200, 0));

      // Close the last segment and confirm every expectation was consumed.
      push(S_UP, 0, 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", q_exp.size(), 0);
      summary_and_finish();
   end

endmodule

`default_nettype wire
